// File: rtl/limb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : limb_pkg
// Description : Shared constants and FSM encoding for the memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package limb_pkg;

    localparam logic [1:0] TRANS_IDLE  = 2'b00;
    localparam logic [1:0] TRANS_NSEQ  = 2'b10;
    localparam logic [1:0] PROT_OPCODE = 2'b00;

    localparam logic GNT_FETCH = 1'b0;
    localparam logic GNT_DATA  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter
// Description : Round-robin arbiter of fetch and data requesters onto one
//               memory port, one transaction outstanding, with wait timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter
    import limb_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    output logic        i_abort,

    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_write,
    input  logic        d_size,
    input  logic [1:0]  d_prot,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_abort,

    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        m_write,
    output logic        m_size,
    output logic [1:0]  m_prot,
    output logic [1:0]  m_trans,
    input  logic [31:0] m_rdata,
    input  logic        m_data_valid,
    input  logic        m_abort
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    state_t             state_q;
    logic               last_gnt_q;
    logic               gnt_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [31:0]        i_rdata_q;
    logic               i_ack_q;
    logic               i_abort_q;
    logic [31:0]        d_rdata_q;
    logic               d_ack_q;
    logic               d_abort_q;
    logic [31:0]        m_addr_q;
    logic [31:0]        m_wdata_q;
    logic               m_write_q;
    logic               m_size_q;
    logic [1:0]         m_prot_q;
    logic [1:0]         m_trans_q;

    logic               any_req_d;
    logic               win_data_d;

    assign any_req_d = i_req | d_req;

    // Data wins alone, or under contention when fetch was granted last.
    always_comb begin
        win_data_d = d_req & (~i_req | (last_gnt_q == GNT_FETCH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= GNT_FETCH;
            gnt_q      <= GNT_FETCH;
            cnt_q      <= '0;
            i_rdata_q  <= '0;
            i_ack_q    <= 1'b0;
            i_abort_q  <= 1'b0;
            d_rdata_q  <= '0;
            d_ack_q    <= 1'b0;
            d_abort_q  <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_write_q  <= 1'b0;
            m_size_q   <= 1'b0;
            m_prot_q   <= 2'b00;
            m_trans_q  <= TRANS_IDLE;
        end else begin
            i_ack_q   <= 1'b0;
            i_abort_q <= 1'b0;
            d_ack_q   <= 1'b0;
            d_abort_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (any_req_d) begin
                        gnt_q      <= win_data_d ? GNT_DATA : GNT_FETCH;
                        last_gnt_q <= win_data_d ? GNT_DATA : GNT_FETCH;
                        if (win_data_d) begin
                            m_addr_q  <= d_addr;
                            m_wdata_q <= d_wdata;
                            m_write_q <= d_write;
                            m_size_q  <= d_size;
                            m_prot_q  <= d_prot;
                        end else begin
                            m_addr_q  <= i_addr;
                            m_wdata_q <= '0;
                            m_write_q <= 1'b0;
                            m_size_q  <= 1'b1;
                            m_prot_q  <= PROT_OPCODE;
                        end
                        m_trans_q <= TRANS_NSEQ;
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    m_trans_q <= TRANS_IDLE;
                    cnt_q     <= '0;
                    state_q   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (m_abort || (!m_data_valid && cnt_q == CNT_LAST)) begin
                        if (gnt_q == GNT_DATA) d_abort_q <= 1'b1;
                        else                   i_abort_q <= 1'b1;
                        if (!m_abort) cnt_q <= CNT_MAX;
                        state_q <= ST_RESP;
                    end else if (m_data_valid) begin
                        // Write responses carry no read data, so rdata is kept.
                        if (gnt_q == GNT_DATA) begin
                            d_ack_q <= 1'b1;
                            if (!m_write_q) d_rdata_q <= m_rdata;
                        end else begin
                            i_ack_q   <= 1'b1;
                            i_rdata_q <= m_rdata;
                        end
                        state_q <= ST_RESP;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign i_rdata = i_rdata_q;
    assign i_ack   = i_ack_q;
    assign i_abort = i_abort_q;
    assign d_rdata = d_rdata_q;
    assign d_ack   = d_ack_q;
    assign d_abort = d_abort_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_write = m_write_q;
    assign m_size  = m_size_q;
    assign m_prot  = m_prot_q;
    assign m_trans = m_trans_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_arbiter
// Description : Directed and randomized transactions against a
//               transaction-level reference model of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_ack, i_abort;
    logic        d_req = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_write = 1'b0;
    logic        d_size = 1'b0;
    logic [1:0]  d_prot = 2'b00;
    logic [31:0] d_rdata;
    logic        d_ack, d_abort;
    logic [31:0] m_addr, m_wdata;
    logic        m_write, m_size;
    logic [1:0]  m_prot, m_trans;
    logic [31:0] m_rdata = '0;
    logic        m_data_valid = 1'b0;
    logic        m_abort = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          last_data = 1'b0;
    logic [31:0] exp_irdata = '0;
    logic [31:0] exp_drdata = '0;

    memory_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_abort(i_abort),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_write(d_write),
        .d_size(d_size), .d_prot(d_prot), .d_rdata(d_rdata), .d_ack(d_ack), .d_abort(d_abort),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_write(m_write), .m_size(m_size),
        .m_prot(m_prot), .m_trans(m_trans), .m_rdata(m_rdata),
        .m_data_valid(m_data_valid), .m_abort(m_abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_pulses(input string tag, input logic [3:0] exp);
        chk({tag, "_pulses"}, {28'd0, i_ack, i_abort, d_ack, d_abort}, {28'd0, exp});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_irdata"}, i_rdata, 32'd0);
        chk({tag, "_drdata"}, d_rdata, 32'd0);
        chk({tag, "_maddr"}, m_addr, 32'd0);
        chk({tag, "_mwdata"}, m_wdata, 32'd0);
        chk({tag, "_ctrl"}, {24'd0, m_write, m_size, m_prot, m_trans, 2'b00}, 32'd0);
        chk_pulses(tag, 4'b0000);
    endtask

    // One transaction, called at a negedge with the DUT idle; returns at a
    // negedge with the DUT idle again. resp_k: WAIT cycle (1-based) of the
    // memory response; anything outside 1..TIMEOUT means no response.
    task automatic run_txn(input string tag, input bit ireq, input bit dreq,
                           input logic [31:0] iaddr, input logic [31:0] daddr,
                           input logic [31:0] dwdata, input bit dwrite, input bit dsize,
                           input logic [1:0] dprot, input int resp_k, input bit abrt,
                           input bit both, input logic [31:0] rdval,
                           input bit drop, input bit noise);
        bit          win_d, responded, aborted;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_ctrl, e_pulse;
        win_d     = dreq && (!ireq || !last_data);
        last_data = win_d;
        e_addr    = win_d ? daddr : iaddr;
        e_wdata   = win_d ? dwdata : 32'd0;
        e_ctrl    = win_d ? {dwrite, dsize, dprot} : 4'b0100;
        responded = (resp_k >= 1) && (resp_k <= TIMEOUT);
        aborted   = !responded || abrt;
        if (win_d) e_pulse = aborted ? 4'b0001 : 4'b0010;
        else       e_pulse = aborted ? 4'b0100 : 4'b1000;
        if (!aborted) begin
            if (!win_d)       exp_irdata = rdval;
            else if (!dwrite) exp_drdata = rdval;
        end

        i_req = ireq; d_req = dreq; i_addr = iaddr; d_addr = daddr;
        d_wdata = dwdata; d_write = dwrite; d_size = dsize; d_prot = dprot;
        @(posedge clk); @(negedge clk);
        chk({tag, "_issue_trans"}, {30'd0, m_trans}, 32'd2);
        chk({tag, "_issue_addr"}, m_addr, e_addr);
        chk({tag, "_issue_wdata"}, m_wdata, e_wdata);
        chk({tag, "_issue_ctrl"}, {28'd0, m_write, m_size, m_prot}, {28'd0, e_ctrl});
        chk_pulses({tag, "_issue"}, 4'b0000);
        if (drop) begin i_req = 1'b0; d_req = 1'b0; end
        if (noise) begin
            m_data_valid = 1'b1; m_abort = 1'($urandom_range(0, 1)); m_rdata = $urandom;
        end
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(posedge clk); @(negedge clk);
            chk({tag, "_wait_trans"}, {30'd0, m_trans}, 32'd0);
            chk({tag, "_wait_hold"}, {m_addr ^ m_wdata}, e_addr ^ e_wdata);
            chk_pulses({tag, "_wait"}, 4'b0000);
            m_data_valid = 1'b0; m_abort = 1'b0; m_rdata = $urandom;
            if (k == resp_k) begin
                m_abort      = abrt;
                m_data_valid = !abrt || both;
                m_rdata      = rdval;
                break;
            end
        end
        @(posedge clk); @(negedge clk);
        m_data_valid = 1'b0; m_abort = 1'b0;
        chk_pulses({tag, "_resp"}, e_pulse);
        chk({tag, "_resp_addr"}, m_addr, e_addr);
        chk({tag, "_resp_wdata"}, m_wdata, e_wdata);
        chk({tag, "_resp_ctrl"}, {28'd0, m_write, m_size, m_prot}, {28'd0, e_ctrl});
        chk({tag, "_resp_irdata"}, i_rdata, exp_irdata);
        chk({tag, "_resp_drdata"}, d_rdata, exp_drdata);
        @(posedge clk); @(negedge clk);
        chk_pulses({tag, "_idle"}, 4'b0000);
        i_req = 1'b0; d_req = 1'b0;
    endtask

    initial begin
        bit ir, dr, ab;
        // Reset state
        #2;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("post_reset");

        // Fetch only, fastest response
        run_txn("fetch", 1, 0, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0, 32'hE3A01005, 0, 0);

        // Contention held: data, fetch, data, fetch
        for (int n = 0; n < 4; n++)
            run_txn("contend", 1, 1, 32'h1000 + n, 32'h2000 + n, $urandom, 0, 1, 2'b01,
                    1, 0, 0, $urandom, 0, 0);

        // Data timeout under contention, then the pending fetch is served
        run_txn("timeout", 1, 1, 32'h300, 32'h400, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        run_txn("after_to", 1, 0, 32'h300, 0, 0, 0, 0, 0, 3, 0, 0, 32'h12345678, 0, 0);

        // Data write keeps d_rdata
        run_txn("dwrite", 0, 1, 0, 32'h200, 32'hDEADBEEF, 1, 1, 2'b11, 1, 0, 0,
                32'hCAFEF00D, 0, 0);

        // Abort and valid together, on each side
        run_txn("abv_d", 0, 1, 0, 32'h500, 0, 0, 0, 2'b10, 2, 1, 1, 32'h0BADF00D, 0, 0);
        run_txn("abv_i", 1, 0, 32'h600, 0, 0, 0, 0, 0, 4, 1, 1, 32'h0BADF00D, 0, 0);

        // Request dropped mid-transaction, with noise during ISSUE
        run_txn("drop", 0, 1, 0, 32'h700, 0, 0, 1, 0, 2, 0, 0, 32'hA5A5A5A5, 1, 1);
        run_txn("last_wait", 1, 0, 32'h800, 0, 0, 0, 0, 0, TIMEOUT, 0, 0, 32'h5A5A5A5A, 0, 1);

        // Reset in WAIT, late response ignored
        d_req = 1'b1; d_addr = 32'h900; d_write = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_all_zero("rst_wait");
        exp_irdata = '0; exp_drdata = '0; last_data = 1'b0;
        @(negedge clk);
        d_req = 1'b0; rst = 1'b1;
        m_data_valid = 1'b1; m_rdata = 32'hFFFF0000;
        repeat (3) begin
            @(negedge clk);
            chk_all_zero("late_resp");
        end
        m_data_valid = 1'b0;
        run_txn("post_rst", 1, 1, 32'hA00, 32'hB00, 0, 0, 0, 2'b01, 1, 0, 0,
                32'h13579BDF, 0, 0);

        // Randomized transactions
        for (int n = 0; n < 24; n++) begin
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            if (!ir && !dr) ir = 1'b1;
            ab = ($urandom_range(0, 3) == 0);
            run_txn("rand", ir, dr, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    int'($urandom_range(1, TIMEOUT + 2)), ab, 1'($urandom_range(0, 1)),
                    $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter SHALL be: TIMEOUT, 15, maximum WAIT cycles before a transaction is aborted.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 i_req  input  1  fetch request, held until i_ack or i_abort; i_addr  input  32  fetch address.
REQ-005 i_rdata  output  32  fetch read data; i_ack  output  1  one-cycle completion pulse; i_abort  output  1  one-cycle abort pulse.
REQ-006 d_req  input  1  data request; d_addr  input  32; d_wdata  input  32; d_write  input  1; d_size  input  1; d_prot  input  2.
REQ-007 d_rdata  output  32; d_ack  output  1; d_abort  output  1; same meaning as the fetch side.
REQ-008 m_addr  output  32; m_wdata  output  32; m_write  output  1; m_size  output  1; m_prot  output  2; m_trans  output  2  drive the shared memory interface.
REQ-009 m_rdata  input  32; m_data_valid  input  1; m_abort  input  1  are memory responses.

Function
REQ-010 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP; only one transaction SHALL be outstanding at a time.
REQ-011 IDLE: the block SHALL sample i_req and d_req; with any request pending it SHALL latch the winner's fields and go to ISSUE, otherwise it SHALL stay in IDLE.
REQ-012 Single request: that requester SHALL win.
REQ-013 Both requests: the requester not granted last SHALL win (round-robin); after reset, last-grant SHALL equal fetch, so data wins the first contention.
REQ-014 A fetch grant SHALL latch m_wdata=0, m_write=0, m_size=1, m_prot=2'b00.
REQ-015 A data grant SHALL latch the d_* fields unchanged.
REQ-016 ISSUE: m_trans SHALL be 2'b10 (NSEQ) for exactly one cycle, then the FSM SHALL go to WAIT.
REQ-017 m_addr/m_wdata/m_write/m_size/m_prot SHALL hold the latched values from ISSUE through RESP.
REQ-018 WAIT: m_trans SHALL be 2'b00; the block SHALL sample m_data_valid and m_abort only in WAIT.
REQ-019 WAIT with m_abort=1: the block SHALL flag abort and go to RESP; m_abort SHALL take precedence when it arrives with m_data_valid in the same cycle.
REQ-020 WAIT with m_data_valid=1 and m_abort=0: the block SHALL latch m_rdata into the granted requester's rdata register and go to RESP.
REQ-021 The wait counter SHALL clear on entry to WAIT and increment each WAIT cycle; when it reaches TIMEOUT with no response, the block SHALL flag abort and go to RESP. The counter SHALL be ceil(log2(TIMEOUT+1)) bits wide and SHALL never wrap.
REQ-022 RESP: the granted requester's ack, or its abort if abort was flagged, SHALL be high for exactly one cycle; the FSM SHALL then return to IDLE.
REQ-023 On abort, rdata SHALL keep its previous value.
REQ-024 Minimum latency SHALL be req sampled in IDLE at cycle N, ISSUE at N+1, m_data_valid at N+2, ack at N+3; back-to-back throughput SHALL be one transaction per 4 cycles.
REQ-025 A requester dropping req mid-transaction SHALL NOT cancel it; the ack/abort pulse SHALL still be generated.
REQ-026 The non-granted requester's ack and abort SHALL stay 0 throughout the transaction.
REQ-027 i_rdata and d_rdata SHALL be registered and SHALL hold their value until the next successful completion for the same requester.

Reset
REQ-028 On rst=0, asynchronously: state SHALL be IDLE, last-grant SHALL be fetch, the counter SHALL be 0, and all outputs SHALL be 0, including m_trans=2'b00.
REQ-029 Reset during ISSUE, WAIT or RESP SHALL abandon the transaction with no ack or abort pulse; memory responses arriving after reset release SHALL be ignored in IDLE.

Structure
REQ-030 A shared package limb_pkg SHALL hold TRANS_IDLE=2'b00, TRANS_NSEQ=2'b10, PROT_OPCODE=2'b00, the FSM state encoding, and the grant identifiers GNT_FETCH and GNT_DATA.
REQ-031 The block SHALL be implemented as one module with no sub-module; grant selection SHALL be inline combinational logic feeding the IDLE-state registers.

Verification
REQ-032 Fetch only: i_req=1, i_addr=0x100, memory returns 0xE3A01005 one cycle after NSEQ -> m_trans=2'b10 at N+1 with m_addr=0x100, m_prot=0, m_size=1; i_ack pulse with i_rdata=0xE3A01005 at N+3; d_ack stays 0.
REQ-033 Contention after reset: i_req=d_req=1 held -> grants alternate data, fetch, data, fetch; each transaction takes 4 cycles.
REQ-034 Data write: d_req=1, d_write=1, d_addr=0x200, d_wdata=0xDEADBEEF -> m_write=1 and m_wdata=0xDEADBEEF held through RESP; d_ack pulses; d_rdata unchanged.
REQ-035 Timeout: no m_data_valid ever, TIMEOUT=15 -> d_abort pulses exactly 15 WAIT cycles after ISSUE, then the FSM is in IDLE and serves the pending i_req.
REQ-036 Simultaneous m_abort=1 and m_data_valid=1 in WAIT -> abort pulse only, no ack, rdata unchanged.
REQ-037 rst=0 asserted during WAIT, then released -> all outputs 0 immediately; no ack or abort ever; a late m_data_valid is ignored; the next request completes normally.
